// File: rtl/mips_mem_pkg.sv
// Shared definitions for the program-image memory loader.
// Optional feature macro used by mem_loader: MEM_LOADER_CHECKSUM_EN.
package mips_mem_pkg;

  localparam int unsigned WORD_W = 32;

  // Memory access-size encodings
  localparam logic [1:0] ACCESS_WORD = 2'b00;
  localparam logic [1:0] ACCESS_HALF = 2'b01;
  localparam logic [1:0] ACCESS_BYTE = 2'b10;

  // Loader defaults
  localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;
  localparam int unsigned DEFAULT_DEPTH      = 1048576;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;
  localparam logic [31:0] WORD_BYTES         = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } loader_state_t;

  // Byte address of the word following a
  function automatic logic [31:0] next_word_addr(input logic [31:0] a);
    return a + WORD_BYTES;
  endfunction

endpackage

// File: rtl/loader_fifo.sv
// Synchronous staging FIFO between the image stream and the memory port.
// A pop only frees a slot for the following cycle; push while full is dropped.
module loader_fifo
  import mips_mem_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] PTR_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == CW'(0));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; flush and reset both empty the queue
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clock) begin
    if (do_push && !reset && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mem_loader.sv
// Streams a program image into memory starting at START_ADDR, then hands
// off to the fetch stage. Writes beyond the window stop the loader in ERROR.
// Optional running checksum of written words: define MEM_LOADER_CHECKSUM_EN.
module mem_loader
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] START_ADDR = DEFAULT_START_ADDR,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [1:0]  access_size,
  output logic        rw,
  output logic        enable,
  input  logic        busy,
  output logic [31:0] words_written,
  output logic        done,
  output logic        error,
  output logic        enable_fetch,
  output logic [31:0] checksum
);

  localparam int unsigned FIFO_CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [32:0] LIMIT   = 33'(START_ADDR) + 33'(DEPTH);

  loader_state_t        state;
  logic [31:0]          head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FIFO_CW-1:0]   fifo_count;
  logic                 active;
  logic                 pending;
  logic                 overflow;
  logic                 accept;
  logic                 wr_done;
  logic                 session_start;

  // Request and handshake decode from registered state
  assign active        = (state == ST_LOAD) || (state == ST_DRAIN);
  assign pending       = active && !fifo_empty;
  assign overflow      = ({1'b0, address} >= LIMIT);
  assign enable        = pending && !overflow;
  assign in_ready      = (state == ST_LOAD) && !fifo_full;
  assign accept        = in_valid && in_ready;
  assign wr_done       = enable && !rw && !busy;
  assign session_start = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign data_in       = fifo_empty ? 32'd0 : head;
  assign access_size   = ACCESS_WORD;

  loader_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (session_start),
    .push  (accept),
    .wdata (in_data),
    .pop   (wr_done),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Loader FSM with registered status, address and write counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      address       <= START_ADDR;
      rw            <= 1'b1;
      words_written <= 32'd0;
      done          <= 1'b0;
      error         <= 1'b0;
      enable_fetch  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state         <= ST_LOAD;
            address       <= START_ADDR;
            rw            <= 1'b0;
            words_written <= 32'd0;
            done          <= 1'b0;
            enable_fetch  <= 1'b0;
          end
        end
        ST_LOAD, ST_DRAIN: begin
          if (pending && overflow) begin
            state <= ST_ERROR;
            rw    <= 1'b1;
            error <= 1'b1;
          end else begin
            if (wr_done) begin
              words_written <= words_written + 32'd1;
              address       <= next_word_addr(address);
            end
            if ((state == ST_LOAD) && accept && in_last) begin
              state <= ST_DRAIN;
            end
            if ((state == ST_DRAIN) &&
                (fifo_empty || (wr_done && fifo_count == FIFO_CW'(1)))) begin
              state        <= ST_DONE;
              address      <= START_ADDR;
              rw           <= 1'b1;
              done         <= 1'b1;
              enable_fetch <= 1'b1;
            end
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state <= ST_IDLE;
          rw    <= 1'b1;
        end
      endcase
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  // Running modulo-2^32 sum of every completed write
  always_ff @(posedge clock) begin
    if (reset || session_start) begin
      checksum <= 32'd0;
    end else if (wr_done) begin
      checksum <= checksum + data_in;
    end
  end
`else
  assign checksum = 32'd0;
`endif

endmodule
